// File: rtl/dom_pkg.sv
// rtl/dom_pkg.sv - share-count and pair-index helpers for the DOM masked AND
package dom_pkg;

  // Number of shares for masking order d.
  function automatic int n_shares(input int d);
    return d + 1;
  endfunction

  // Number of fresh random words: one per unordered share pair.
  function automatic int n_rand(input int d);
    int n;
    n = d + 1;
    return (n * (n - 1)) / 2;
  endfunction

  // Lexicographic index of the unordered pair {i,j}, i != j, among n shares.
  function automatic int pair_idx(input int i, input int j, input int n);
    int a;
    int b;
    a = (i < j) ? i : j;
    b = (i < j) ? j : i;
    return a * n - (a * (a + 1)) / 2 + (b - a - 1);
  endfunction

endpackage

// File: rtl/dom_cross_cell.sv
// rtl/dom_cross_cell.sv - one registered DOM term: (a & b) optionally masked with r
module dom_cross_cell #(
  parameter int W     = 1,
  parameter bit USE_R = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] r,
  output logic [W-1:0] q
);

  logic [W-1:0] mask;

  // Diagonal terms carry no randomness; cross terms are masked before the register.
  assign mask = USE_R ? r : '0;

  // Load the masked product on fire, zeroise on idle clear, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= (a & b) ^ mask;
    end else if (clear) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/dom_and_pipe.sv
// rtl/dom_and_pipe.sv - pipelined DOM-indep masked AND with valid/ready and randomness handshake
module dom_and_pipe
  import dom_pkg::*;
#(
  parameter int D             = 2,
  parameter int W             = 1,
  parameter bit CLEAR_ON_IDLE = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [n_shares(D)*W-1:0]    x,
  input  logic [n_shares(D)*W-1:0]    y,
  input  logic                        rand_valid,
  output logic                        rand_ready,
  input  logic [W*n_rand(D)-1:0]      r,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [n_shares(D)*W-1:0]    z
);

  localparam int N = n_shares(D);

  logic         fire;
  logic         clear;
  logic [W-1:0] p [N][N];

  // Accept whenever the output slot is free or being drained this cycle.
  // rst_n gates fire so no randomness is reported consumed while in reset.
  assign in_ready   = !out_valid || out_ready;
  assign fire       = in_valid && rand_valid && in_ready && rst_n;
  assign rand_ready = fire;
  assign clear      = CLEAR_ON_IDLE && !fire && in_ready;

  // Term register array: diagonal terms unmasked, cross terms masked with the pair's random word.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (i == j) begin : g_diag
        dom_cross_cell #(.W(W), .USE_R(1'b0)) u_cell (
          .clk   (clk),
          .rst_n (rst_n),
          .load  (fire),
          .clear (clear),
          .a     (x[i*W +: W]),
          .b     (y[j*W +: W]),
          .r     ({W{1'b0}}),
          .q     (p[i][j])
        );
      end else begin : g_cross
        localparam int K = pair_idx(i, j, N);
        dom_cross_cell #(.W(W), .USE_R(1'b1)) u_cell (
          .clk   (clk),
          .rst_n (rst_n),
          .load  (fire),
          .clear (clear),
          .a     (x[i*W +: W]),
          .b     (y[j*W +: W]),
          .r     (r[K*W +: W]),
          .q     (p[i][j])
        );
      end
    end
  end

  // Output valid: set on fire, dropped once consumed without a replacement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Compression: each output share is the XOR of its row of registered terms only.
  always_comb begin
    z = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        z[i*W +: W] = z[i*W +: W] ^ p[i][j];
      end
    end
  end

endmodule

// File: tb/tb_dom_and_pipe.sv
// tb/tb_dom_and_pipe.sv - scoreboard bench for dom_and_pipe
module tb_dom_and_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, rand_valid, out_ready;
  logic [2:0]  x, y, r;
  logic        in_ready, rand_ready, out_valid;
  logic [2:0]  z;
  logic        in_ready_h, rand_ready_h, out_valid_h;
  logic [2:0]  z_h;

  logic        b_in_valid, b_rand_valid, b_out_ready;
  logic [31:0] b_x, b_y, b_z;
  logic [47:0] b_r;
  logic        b_in_ready, b_rand_ready, b_out_valid;

  int checks = 0;
  int errors = 0;

  logic [3:0] sb [$];
  logic [7:0] bsb [$];

  always #5 clk = ~clk;

  dom_and_pipe #(.D(2), .W(1), .CLEAR_ON_IDLE(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .rand_valid(rand_valid), .rand_ready(rand_ready), .r(r),
    .out_valid(out_valid), .out_ready(out_ready), .z(z)
  );

  dom_and_pipe #(.D(2), .W(1), .CLEAR_ON_IDLE(1'b0)) u_hold (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_h),
    .x(x), .y(y), .rand_valid(rand_valid), .rand_ready(rand_ready_h), .r(r),
    .out_valid(out_valid_h), .out_ready(out_ready), .z(z_h)
  );

  dom_and_pipe #(.D(3), .W(8), .CLEAR_ON_IDLE(1'b1)) u_big (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .y(b_y), .rand_valid(b_rand_valid), .rand_ready(b_rand_ready), .r(b_r),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .z(b_z)
  );

  function automatic logic [2:0] model_z(input logic [2:0] xa, input logic [2:0] ya,
                                         input logic [2:0] ra);
    logic [2:0] zz;
    zz = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (i == j) zz[i] = zz[i] ^ (xa[i] & ya[i]);
        else        zz[i] = zz[i] ^ ((xa[i] & ya[j]) ^ ra[i+j-1]);
      end
    end
    return zz;
  endfunction

  function automatic logic [7:0] xor4(input logic [31:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24];
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic op(input logic [2:0] xa, input logic [2:0] ya, input logic [2:0] ra);
    x = xa; y = ya; r = ra;
    in_valid = 1'b1; rand_valid = 1'b1;
    sb.push_back({(^xa) & (^ya), model_z(xa, ya, ra)});
  endtask

  task automatic idle();
    in_valid = 1'b0; rand_valid = 1'b0;
  endtask

  // Scoreboard for the D=2 instance: pop on every consumed result.
  always @(negedge clk) begin
    logic [3:0] e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected z=%b (no result expected)", z);
      end else begin
        e = sb.pop_front();
        if (z !== e[2:0] || (^z) !== e[3]) begin
          errors++;
          $display("FAIL sb_result z=%b xor=%b expected z=%b xor=%b", z, ^z, e[2:0], e[3]);
        end
      end
    end
  end

  // Scoreboard for the D=3, W=8 instance: unshared value only.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n && b_out_valid && b_out_ready) begin
      checks++;
      if (bsb.size() == 0) begin
        errors++;
        $display("FAIL big_unexpected z=%h", b_z);
      end else begin
        e = bsb.pop_front();
        if (xor4(b_z) !== e) begin
          errors++;
          $display("FAIL big_unshare got=%h expected=%h", xor4(b_z), e);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; rand_valid = 1'b1; out_ready = 1'b0;
    x = 3'b111; y = 3'b111; r = 3'b000;
    b_in_valid = 1'b0; b_rand_valid = 1'b0; b_out_ready = 1'b1;
    b_x = '0; b_y = '0; b_r = '0;
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || z !== 3'b000 || in_ready !== 1'b1 || rand_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ov=%b z=%b ir=%b rr=%b expected 0 000 1 0",
               out_valid, z, in_ready, rand_ready);
    end
    idle(); out_ready = 1'b1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    op(3'b001, 3'b010, 3'b000);
    #1;
    checks++;
    if (in_ready !== 1'b1 || rand_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept ir=%b rr=%b expected 1 1", in_ready, rand_ready);
    end
    step(); idle(); #1;
    checks++;
    if (out_valid !== 1'b1 || z !== 3'b001 || (^z) !== 1'b1) begin
      errors++;
      $display("FAIL basic_r0 ov=%b z=%b expected 1 001", out_valid, z);
    end
    step(); #1;
    checks++;
    if (out_valid !== 1'b0 || z !== 3'b000 || z_h !== 3'b001) begin
      errors++;
      $display("FAIL idle_clear ov=%b z=%b z_hold=%b expected 0 000 001", out_valid, z, z_h);
    end
    op(3'b001, 3'b010, 3'b111);
    step(); idle(); #1;
    checks++;
    if (out_valid !== 1'b1 || z !== 3'b001) begin
      errors++;
      $display("FAIL basic_r7 ov=%b z=%b expected 1 001", out_valid, z);
    end
    step(); #1;
    checks++;
    if (z !== 3'b000 || z_h !== 3'b001) begin
      errors++;
      $display("FAIL idle_clear2 z=%b z_hold=%b expected 000 001", z, z_h);
    end
  endtask

  task automatic test_missing_rand();
    x = 3'b110; y = 3'b011; r = 3'b101;
    in_valid = 1'b1; rand_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (rand_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL norand_wait cyc=%0d rr=%b ov=%b expected 0 0", k, rand_ready, out_valid);
      end
      step();
    end
    op(3'b110, 3'b011, 3'b101);
    #1;
    checks++;
    if (rand_ready !== 1'b1) begin
      errors++;
      $display("FAIL norand_fire rr=%b expected 1", rand_ready);
    end
    step();
    in_valid = 1'b0;
    #1;
    checks++;
    if (rand_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rand_once rr=%b ov=%b expected 0 1", rand_ready, out_valid);
    end
    step(); #1;
    checks++;
    if (out_valid !== 1'b0 || rand_ready !== 1'b0) begin
      errors++;
      $display("FAIL rand_alone ov=%b rr=%b expected 0 0", out_valid, rand_ready);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      op(3'($urandom), 3'($urandom), 3'($urandom));
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready op=%0d ir=%b expected 1", k, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_valid op=%0d ov=%b expected 1", k, out_valid);
      end
    end
    idle();
    step();
  endtask

  task automatic test_stall();
    logic [2:0] ea, eb;
    ea = model_z(3'b101, 3'b111, 3'b010);
    eb = model_z(3'b011, 3'b001, 3'b100);
    out_ready = 1'b0;
    op(3'b101, 3'b111, 3'b010);
    step();
    x = 3'b000; y = 3'b110; r = 3'b111;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || rand_ready !== 1'b0 || out_valid !== 1'b1 || z !== ea) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d ir=%b rr=%b ov=%b z=%b expected 0 0 1 %b",
                 k, in_ready, rand_ready, out_valid, z, ea);
      end
      step();
    end
    out_ready = 1'b1;
    op(3'b011, 3'b001, 3'b100);
    #1;
    checks++;
    if (rand_ready !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release rr=%b ir=%b expected 1 1", rand_ready, in_ready);
    end
    step(); idle(); #1;
    checks++;
    if (out_valid !== 1'b1 || z !== eb) begin
      errors++;
      $display("FAIL consume_and_fire ov=%b z=%b expected 1 %b", out_valid, z, eb);
    end
    step();
  endtask

  task automatic test_random();
    logic exp_ov, exp_ready, fire;
    int fires, cyc;
    exp_ov = 1'b0; fires = 0; cyc = 0;
    while (fires < 10000 && cyc < 30000) begin
      x = 3'($urandom); y = 3'($urandom); r = 3'($urandom);
      in_valid = 1'b1;
      rand_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(4) != 0);
      exp_ready = !exp_ov || out_ready;
      fire = rand_valid && exp_ready;
      if (fire) begin
        sb.push_back({(^x) & (^y), model_z(x, y, r)});
        fires++;
      end
      #1;
      checks++;
      if (in_ready !== exp_ready || rand_ready !== fire) begin
        errors++;
        $display("FAIL rand_hs cyc=%0d ir=%b rr=%b expected %b %b",
                 cyc, in_ready, rand_ready, exp_ready, fire);
      end
      exp_ov = fire ? 1'b1 : (out_ready ? 1'b0 : exp_ov);
      step();
      cyc++;
    end
    checks++;
    if (fires < 10000) begin
      errors++;
      $display("FAIL rand_budget fires=%0d expected 10000", fires);
    end
    idle(); out_ready = 1'b1;
    step(); step();
  endtask

  task automatic test_big();
    b_out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      b_x = $urandom; b_y = $urandom; b_r = {16'($urandom), 32'($urandom)};
      b_in_valid = 1'b1; b_rand_valid = 1'b1;
      bsb.push_back(xor4(b_x) & xor4(b_y));
      step();
    end
    b_in_valid = 1'b0; b_rand_valid = 1'b0;
    step(); step();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    op(3'b111, 3'b111, 3'b011);
    step(); idle(); #1;
    checks++;
    if (out_valid !== 1'b1 || z === 3'b000) begin
      errors++;
      $display("FAIL pre_reset ov=%b z=%b expected 1 nonzero", out_valid, z);
    end
    rst_n = 1'b0;
    in_valid = 1'b1; rand_valid = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || z !== 3'b000 || z_h !== 3'b000 ||
        in_ready !== 1'b1 || rand_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset ov=%b z=%b zh=%b ir=%b rr=%b expected 0 000 000 1 0",
               out_valid, z, z_h, in_ready, rand_ready);
    end
    sb.delete();
    step();
    idle(); out_ready = 1'b1;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_missing_rand();
    test_back_to_back();
    test_stall();
    test_random();
    test_big();
    test_reset_mid_stall();
    checks++;
    if (sb.size() != 0 || bsb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover small=%0d big=%0d expected 0 0", sb.size(), bsb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
